// File: rtl/mem_arb_pkg.sv
// Shared types for the data-RAM port arbiter.
//   arb_state_t : access sequencer states (issue -> wait -> acknowledge)
//   grant_t     : which requester owns the current transaction
//   CNT_W       : latency counter width, enough for MEM_LATENCY up to 15
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
    typedef enum logic       {GNT_CPU, GNT_HOST}        grant_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_rr2.sv
// arb_rr2: combinational 2-way round-robin picker.
//   req[0] : CPU request      req[1] : host request
//   lock   : 1 = CPU is not eligible
//   last   : requester served by the previous transaction
//   valid  : some eligible requester is present
//   grant  : chosen requester (meaningful only when valid)
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       lock,
    input  grant_t     last,
    output logic       valid,
    output grant_t     grant
);

    logic cpu_ok;

    assign cpu_ok = req[0] & ~lock;

    always_comb begin
        valid = cpu_ok | req[1];
        grant = GNT_CPU;
        if (cpu_ok && req[1]) begin
            // contention: hand the port to whoever did not have it last
            grant = (last == GNT_CPU) ? GNT_HOST : GNT_CPU;
        end else if (req[1]) begin
            grant = GNT_HOST;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-RAM port between the RISC-V core and the
// FPGA host/loader. Every access runs IDLE -> ISSUE -> WAIT -> DONE, so the
// requester sees its ack MEM_LATENCY+2 cycles after its request is sampled.
//   clk, nrst          : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  -> CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack     <- CPU read data (held between acks), done pulse
//   cpu_stall              <- cpu_req & ~cpu_ack, freezes the core PC
//   host_req/we/addr/wdata -> host request, same protocol
//   host_rdata, host_ack   <- host read data, done pulse
//   host_lock              -> 1 = CPU is never granted
//   mem_en/we/addr/wdata   <- RAM strobe (one cycle per access) and command
//   mem_rdata              -> RAM data, valid MEM_LATENCY cycles after mem_en
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2     // 1..15
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    input  logic              host_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state, state_d;
    grant_t            last_grant, gnt, pick;
    logic              pick_valid;
    logic [CNT_W-1:0]  cnt;
    logic              mem_en_q, mem_we_q, cpu_ack_q, host_ack_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, cpu_rdata_q, host_rdata_q;

    arb_rr2 u_rr (
        .req   ({host_req, cpu_req}),
        .lock  (host_lock),
        .last  (last_grant),
        .valid (pick_valid),
        .grant (pick)
    );

    // state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_d;
    end

    // next state
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath. Strobes and acks are registered one state early so they are
    // high exactly while the FSM sits in ISSUE (mem_en) or DONE (ack).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_grant   <= GNT_HOST;     // CPU wins the first tie
            gnt          <= GNT_CPU;
            cnt          <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            host_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt      <= pick;
                        mem_en_q <= 1'b1;
                        if (pick == GNT_HOST) begin
                            mem_we_q <= host_we;
                            addr_q   <= host_addr;
                            wdata_q  <= host_wdata;
                        end else begin
                            mem_we_q <= cpu_we;
                            addr_q   <= cpu_addr;
                            wdata_q  <= cpu_wdata;
                        end
                    end
                end
                ISSUE: cnt <= CNT_W'(MEM_LATENCY - 1);
                WAIT: begin
                    if (cnt == '0) begin
                        // writes capture too; the access is uniform either way
                        if (gnt == GNT_HOST) begin
                            host_rdata_q <= mem_rdata;
                            host_ack_q   <= 1'b1;
                        end else begin
                            cpu_rdata_q  <= mem_rdata;
                            cpu_ack_q    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    last_grant <= gnt;
                default: ;
            endcase
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign host_ack   = host_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign host_rdata = host_rdata_q;
    assign cpu_stall  = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LATENCY=2. A behavioural RAM
// returns data two cycles after mem_en; expected acks (port + rdata) are
// queued when requests are raised and popped when an ack appears.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    typedef struct {
        bit          host;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        cpu_req, cpu_we, host_req, host_we, host_lock;
    logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata, mem_rdata;
    logic [31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata;
    logic        cpu_ack, cpu_stall, host_ack, mem_en, mem_we;

    logic [31:0] ram [0:63];
    logic [31:0] rd_data;
    int          rd_cnt;
    logic        prev_men;
    exp_t        sb [$];
    int          cyc, t0, men_cyc, cpu_ack_cyc, host_ack_cyc, stall_cnt;
    logic [31:0] men_addr;
    int          checks = 0;
    int          errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .nrst(nrst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack), .host_lock(host_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // one clock: RAM model, per-cycle invariants, ack scoreboard
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (rd_cnt > 0) begin
            rd_cnt--;
            mem_rdata = (rd_cnt == 0) ? rd_data : JUNK;
        end else begin
            mem_rdata = JUNK;
        end
        chk("ack_excl", 32'(cpu_ack & host_ack), 32'd0);
        chk("stall", 32'(cpu_stall), 32'(cpu_req & ~cpu_ack));
        if (mem_en) begin
            chk("men_pulse", 32'(prev_men), 32'd0);
            rd_data  = ram[mem_addr[7:2]];
            rd_cnt   = LAT;
            if (mem_we) ram[mem_addr[7:2]] = mem_wdata;
            men_cyc  = cyc;
            men_addr = mem_addr;
        end
        prev_men = mem_en;
        if (cpu_stall) stall_cnt++;
        if (cpu_ack || host_ack) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", 32'({host_ack, cpu_ack}), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", 32'(host_ack), 32'(e.host));
                chk("ack_rdata", e.host ? host_rdata : cpu_rdata, e.rdata);
            end
            if (cpu_ack)  begin cpu_ack_cyc  = cyc; cpu_req  = 1'b0; end
            if (host_ack) begin host_ack_cyc = cyc; host_req = 1'b0; end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (sb.size() > 0) begin
            chk("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
            cpu_req  = 1'b0;
            host_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        nrst = 1'b0; cpu_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
        rd_cnt = 0; sb.delete();
        step();
        step();
        nrst = 1'b1;
    endtask

    task automatic set_cpu(input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    endtask

    task automatic set_host(input logic we, input logic [31:0] a, input logic [31:0] d);
        host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
    endtask

    initial begin
        cyc = 0; rd_cnt = 0; prev_men = 1'b0; stall_cnt = 0; mem_rdata = JUNK;
        men_cyc = 0; men_addr = '0; cpu_ack_cyc = 0; host_ack_cyc = 0;
        cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[32'h10 >> 2] = 32'h1234_5678;
        ram[32'h24 >> 2] = 32'hA5A5_0024;
        ram[32'h30 >> 2] = 32'h3030_3030;
        ram[32'h40 >> 2] = 32'h0000_00C0;

        // reset values
        do_reset();
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_host_ack", 32'(host_ack), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_host_rdata", host_rdata, 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);

        // CPU read alone: mem_en at +1, ack at +4, stall in cycles 0-3
        set_cpu(1'b0, 32'h10, 32'h0);
        t0 = cyc;
        #1 chk("t1_stall_c0", 32'(cpu_stall), 32'd1);
        stall_cnt = 0;
        sb.push_back('{1'b0, 32'h1234_5678});
        drain(40);
        chk("t1_men_cyc", 32'(men_cyc - t0), 32'd1);
        chk("t1_men_addr", men_addr, 32'h10);
        chk("t1_ack_cyc", 32'(cpu_ack_cyc - t0), 32'd4);
        chk("t1_stall_cnt", 32'(stall_cnt), 32'd3);

        // tie from reset: CPU first, host after an IDLE gap, next tie CPU again
        do_reset();
        set_cpu(1'b1, 32'h20, 32'hDEAD_BEEF);
        set_host(1'b0, 32'h20, 32'h0);
        t0 = cyc;
        sb.push_back('{1'b0, 32'h0000_0000});
        sb.push_back('{1'b1, 32'hDEAD_BEEF});
        drain(40);
        chk("tie_cpu_cyc", 32'(cpu_ack_cyc - t0), 32'd4);
        chk("tie_gap", 32'(host_ack_cyc - cpu_ack_cyc), 32'd5);
        set_cpu(1'b0, 32'h24, 32'h0);
        set_host(1'b1, 32'h24, 32'h1111_2222);
        sb.push_back('{1'b0, 32'hA5A5_0024});
        sb.push_back('{1'b1, 32'hA5A5_0024});
        drain(40);
        chk("tie3_order", 32'(host_ack_cyc > cpu_ack_cyc), 32'd1);
        chk("ram_20", ram[32'h20 >> 2], 32'hDEAD_BEEF);
        chk("ram_24", ram[32'h24 >> 2], 32'h1111_2222);

        // host_lock: three host transactions while the CPU waits
        host_lock = 1'b1;
        set_cpu(1'b0, 32'h30, 32'h0);
        t0 = cyc;
        stall_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            set_host(1'b0, 32'h10, 32'h0);
            sb.push_back('{1'b1, 32'h1234_5678});
            drain(40);
        end
        chk("lock_stall_cycles", 32'(stall_cnt), 32'(cyc - t0));
        chk("lock_stall_now", 32'(cpu_stall), 32'd1);
        host_lock = 1'b0;
        sb.push_back('{1'b0, 32'h3030_3030});
        drain(40);

        // lock raised while the CPU is in WAIT: CPU finishes, host is next
        set_cpu(1'b0, 32'h10, 32'h0);
        sb.push_back('{1'b0, 32'h1234_5678});
        sb.push_back('{1'b1, 32'h3030_3030});
        step();
        step();
        host_lock = 1'b1;
        set_host(1'b0, 32'h30, 32'h0);
        drain(40);
        host_lock = 1'b0;

        // reset during WAIT: outputs clear at once, no ack, re-request works
        set_cpu(1'b0, 32'h24, 32'h0);
        step();
        step();
        nrst = 1'b0; cpu_req = 1'b0; rd_cnt = 0;
        #1;
        chk("wrst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("wrst_mem_en", 32'(mem_en), 32'd0);
        chk("wrst_cpu_rdata", cpu_rdata, 32'd0);
        chk("wrst_host_rdata", host_rdata, 32'd0);
        chk("wrst_mem_addr", mem_addr, 32'd0);
        step();
        nrst = 1'b1;
        repeat (4) step();
        set_cpu(1'b0, 32'h24, 32'h0);
        t0 = cyc;
        sb.push_back('{1'b0, 32'h1111_2222});
        drain(40);
        chk("wrst_reissue_cyc", 32'(cpu_ack_cyc - t0), 32'd4);

        // host write then CPU read of the same word
        set_host(1'b1, 32'h40, 32'h0000_0007);
        sb.push_back('{1'b1, 32'h0000_00C0});
        drain(40);
        set_cpu(1'b0, 32'h40, 32'h0);
        sb.push_back('{1'b0, 32'h0000_0007});
        drain(40);
        chk("host_rdata_kept", host_rdata, 32'h0000_00C0);
        chk("cpu_rdata_40", cpu_rdata, 32'h0000_0007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
